// File: rtl/shm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shm_pkg
// Description : Shared Scroll Hat Mini geometry and LED index mapping.
// Revision    : 1.0
// ============================================================================
package shm_pkg;

    localparam int SHM_NUM_COLS = 17;
    localparam int SHM_NUM_ROWS = 7;
    localparam int SHM_NUM_LEDS = SHM_NUM_COLS * SHM_NUM_ROWS;

    // Column-major-within-row layout used by the display updater.
    function automatic int unsigned shm_led_index(input int unsigned col, input int unsigned row);
        return col + SHM_NUM_COLS * row;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shm_column_scroller_if.sv
`default_nettype none
// ============================================================================
// Module      : shm_column_scroller_if
// Description : Column input stream and frame output handshake.
// Revision    : 1.0
// ============================================================================
interface shm_column_scroller_if
    import shm_pkg::*;
#(
    parameter int NUM_COLS = SHM_NUM_COLS,
    parameter int NUM_ROWS = SHM_NUM_ROWS
);
    logic                         col_valid;
    logic [NUM_ROWS-1:0]          col_data;
    logic                         col_ready;
    logic [NUM_COLS*NUM_ROWS-1:0] frame;
    logic                         frame_valid;
    logic                         frame_ready;

    // master: column source / frame consumer; slave: the scroller
    modport master (
        output col_valid, col_data, frame_ready,
        input  col_ready, frame, frame_valid
    );
    modport slave (
        input  col_valid, col_data, frame_ready,
        output col_ready, frame, frame_valid
    );
endinterface
`default_nettype wire

// File: rtl/shm_col_fifo.sv
`default_nettype none
// ============================================================================
// Module      : shm_col_fifo
// Description : Synchronous first-word-fall-through FIFO for LED columns.
// Revision    : 1.0
// ============================================================================
module shm_col_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 32
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic                       clear,
    input  wire logic [WIDTH-1:0]           din,
    output logic      [WIDTH-1:0]           dout,
    output logic                            full,
    output logic                            empty,
    output logic      [$clog2(DEPTH+1)-1:0] count
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_aw-1:0]  wr_ptr_q;
    logic [c_aw-1:0]  rd_ptr_q;
    logic [c_cw-1:0]  count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear && !reset) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == c_cw'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/shm_column_scroller.sv
`default_nettype none
// ============================================================================
// Module      : shm_column_scroller
// Description : Queues LED columns and scrolls them leftward through a frame.
// Revision    : 1.0
// ============================================================================
module shm_column_scroller
    import shm_pkg::*;
#(
    parameter int NUM_COLS   = SHM_NUM_COLS,
    parameter int NUM_ROWS   = SHM_NUM_ROWS,
    parameter int FIFO_DEPTH = 32,
    parameter int TICK_DIV   = 5_000_000,
    parameter int PAD_BLANK  = 1
) (
    input  wire logic                            clk,
    input  wire logic                            reset,
    input  wire logic                            enable,
    input  wire logic                            flush,
    shm_column_scroller_if.slave                 bus,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
    output logic                                 idle
);
    localparam int                c_cnt_w  = $clog2(TICK_DIV);
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0]           cnt_q, cnt_d;
    logic                         tick_due_q, tick_due_d;
    logic [NUM_COLS*NUM_ROWS-1:0] frame_q, frame_d;
    logic                         frame_valid_q, frame_valid_d;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [NUM_ROWS-1:0] w_fifo_head;
    logic [NUM_ROWS-1:0] w_col_in;
    logic                w_push, w_pop, w_tick, w_shift, w_advance, w_xfer;

    assign w_tick    = enable && (cnt_q == '0);
    assign w_shift   = tick_due_q && (!frame_valid_q || bus.frame_ready);
    assign w_advance = w_shift && (!w_fifo_empty || (PAD_BLANK != 0));
    assign w_xfer    = frame_valid_q && bus.frame_ready;
    assign w_push    = bus.col_valid && !w_fifo_full && !flush;
    assign w_pop     = w_shift && !w_fifo_empty && !flush;
    assign w_col_in  = w_fifo_empty ? '0 : w_fifo_head;

    shm_col_fifo #(
        .WIDTH (NUM_ROWS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .clear (flush),
        .din   (bus.col_data),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        cnt_d         = cnt_q;
        tick_due_d    = tick_due_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;

        if (enable) cnt_d = (cnt_q == '0) ? c_reload : cnt_q - 1'b1;

        // A fresh tick landing on the consuming shift stays pending.
        if (w_shift) tick_due_d = 1'b0;
        if (w_tick)  tick_due_d = 1'b1;

        if (w_advance) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < NUM_COLS - 1; c++) begin
                    frame_d[c + NUM_COLS*r] = frame_q[c + 1 + NUM_COLS*r];
                end
                frame_d[NUM_COLS - 1 + NUM_COLS*r] = w_col_in[r];
            end
            frame_valid_d = 1'b1;
        end else if (w_xfer) begin
            frame_valid_d = 1'b0;
        end

        if (flush) begin
            cnt_d         = c_reload;
            tick_due_d    = 1'b0;
            frame_d       = '0;
            frame_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= c_reload;
            tick_due_q    <= 1'b0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            tick_due_q    <= tick_due_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign bus.col_ready   = !w_fifo_full;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign idle            = w_fifo_empty && !frame_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_shm_column_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_shm_column_scroller
// Description : Directed and randomized checks against a queue-based model.
// Revision    : 1.0
// ============================================================================
module tb_shm_column_scroller;
    import shm_pkg::*;

    localparam int TD    = 4;
    localparam int DEPTH = 32;
    localparam int NC    = SHM_NUM_COLS;
    localparam int NR    = SHM_NUM_ROWS;

    logic       clk = 1'b0;
    logic       reset, enable, flush;
    logic [5:0] fifo_count;
    logic       idle;

    shm_column_scroller_if #(.NUM_COLS(NC), .NUM_ROWS(NR)) bus ();

    shm_column_scroller #(
        .NUM_COLS   (NC),
        .NUM_ROWS   (NR),
        .FIFO_DEPTH (DEPTH),
        .TICK_DIV   (TD),
        .PAD_BLANK  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .flush      (flush),
        .bus        (bus),
        .fifo_count (fifo_count),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: a column queue, a column array and a pending-step flag.
    logic [NR-1:0] m_q [$];
    logic [NR-1:0] m_cols [NC];
    bit            m_fv  = 1'b0;
    bit            m_due = 1'b0;
    int            m_en  = 0;

    function automatic logic [NC*NR-1:0] m_frame();
        logic [NC*NR-1:0] f = '0;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                f[shm_led_index(c, r)] = m_cols[c][r];
        return f;
    endfunction

    function automatic logic [NR-1:0] col_of(input logic [NC*NR-1:0] f, input int c);
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = f[shm_led_index(c, r)];
        return v;
    endfunction

    task automatic model_step();
        bit            tick, go, acc, xfer, had;
        logic [NR-1:0] nc;
        if (reset) begin
            m_q.delete();
            for (int c = 0; c < NC; c++) m_cols[c] = '0;
            m_fv = 0; m_due = 0; m_en = 0;
        end else if (flush) begin
            m_q.delete();
            for (int c = 0; c < NC; c++) m_cols[c] = '0;
            m_fv = 1; m_due = 0; m_en = 0;
        end else begin
            tick = enable && (m_en % TD == TD - 1);
            go   = m_due && (!m_fv || bus.frame_ready);
            acc  = bus.col_valid && (m_q.size() < DEPTH);
            xfer = m_fv && bus.frame_ready;
            had  = m_q.size() > 0;
            nc   = '0;
            if (enable) m_en++;
            if (go && had) nc = m_q.pop_front();
            if (acc) m_q.push_back(bus.col_data);
            if (go) begin
                for (int c = 0; c < NC - 1; c++) m_cols[c] = m_cols[c+1];
                m_cols[NC-1] = nc;
                m_fv = 1;
            end else if (xfer) begin
                m_fv = 0;
            end
            if (tick) m_due = 1;
            else if (go) m_due = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("frame", bus.frame, m_frame());
        chk("frame_valid", bus.frame_valid, m_fv);
        chk("col_ready", bus.col_ready, m_q.size() < DEPTH);
        chk("fifo_count", fifo_count, m_q.size());
        chk("idle", idle, (m_q.size() == 0) && !m_fv);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; flush = 1'b0;
        bus.col_valid = 1'b0; bus.col_data = '0; bus.frame_ready = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic wait_fv(input string tag);
        int i = 0;
        while (!bus.frame_valid && i < 60) begin cycle(); i++; end
        if (!bus.frame_valid) chk({tag, "_timeout"}, 0, 1);
    endtask

    logic [NC*NR-1:0] exp_f;
    logic [NR-1:0]    ca, cb;
    int               n;

    initial begin
        for (int c = 0; c < NC; c++) m_cols[c] = '0;

        // Reset held three cycles
        reset = 1'b1; enable = 1'b0; flush = 1'b0;
        bus.col_valid = 1'b0; bus.col_data = '0; bus.frame_ready = 1'b0;
        repeat (3) cycle();
        chk("rst_frame", bus.frame, 0);
        chk("rst_fv", bus.frame_valid, 0);
        chk("rst_ready", bus.col_ready, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_idle", idle, 1);
        reset = 1'b0;

        // Single all-lit column reaches the right edge
        enable = 1'b1; bus.frame_ready = 1'b1;
        bus.col_valid = 1'b1; bus.col_data = 7'h7F;
        cycle();
        bus.col_valid = 1'b0;
        wait_fv("single");
        exp_f = '0;
        for (int r = 0; r < NR; r++) exp_f[16 + 17*r] = 1'b1;
        chk("single_frame", bus.frame, exp_f);
        chk("single_count", fifo_count, 0);
        cycle();
        chk("single_fv_pulse", bus.frame_valid, 0);

        // Seventeen columns fill the display, then a blank pad
        do_reset();
        for (int k = 0; k < 17; k++) begin
            bus.col_valid = 1'b1; bus.col_data = 7'(k + 1);
            cycle();
        end
        bus.col_valid = 1'b0;
        enable = 1'b1; bus.frame_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 400 && n < 17; i++) begin
            cycle();
            if (bus.frame_valid) n++;
        end
        chk("fill_shifts", n, 17);
        for (int c = 0; c < NC; c++) exp_f[NC*NR-1:0] = exp_f;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                exp_f[shm_led_index(c, r)] = 1'(((c + 1) >> r) & 1);
        chk("fill_frame", bus.frame, exp_f);
        n = 0;
        do begin cycle(); n++; end while (!bus.frame_valid && n < 40);
        chk("pad_fv", bus.frame_valid, 1);
        chk("pad_col16", col_of(bus.frame, 16), 0);
        chk("pad_col15", col_of(bus.frame, 15), 17);

        // Backpressure holds the frame and the queue
        do_reset();
        ca = 7'h15; cb = 7'h2A;
        bus.col_valid = 1'b1;
        bus.col_data = ca;    cycle();
        bus.col_data = cb;    cycle();
        bus.col_data = 7'h33; cycle();
        bus.col_data = 7'h4C; cycle();
        bus.col_valid = 1'b0;
        enable = 1'b1;
        wait_fv("bp");
        repeat (40) cycle();
        exp_f = '0;
        for (int r = 0; r < NR; r++) exp_f[shm_led_index(16, r)] = ca[r];
        chk("bp_frame_stable", bus.frame, exp_f);
        chk("bp_count_held", fifo_count, 3);
        bus.frame_ready = 1'b1;
        cycle();
        bus.frame_ready = 1'b0;
        chk("bp_one_shift_count", fifo_count, 2);
        chk("bp_col15", col_of(bus.frame, 15), ca);
        chk("bp_col16", col_of(bus.frame, 16), cb);
        chk("bp_fv_kept", bus.frame_valid, 1);

        // FIFO fill to full with the scroll halted
        do_reset();
        for (int k = 0; k < 33; k++) begin
            if (k == 32) begin
                chk("full_ready", bus.col_ready, 0);
                chk("full_count32", fifo_count, 32);
            end
            bus.col_valid = 1'b1; bus.col_data = 7'($urandom);
            cycle();
        end
        bus.col_valid = 1'b0;
        chk("full_count_after33", fifo_count, 32);

        // Flush mid-scroll drops the queue and a same-cycle push
        do_reset();
        for (int k = 0; k < 6; k++) begin
            bus.col_valid = 1'b1; bus.col_data = 7'($urandom) | 7'h01;
            cycle();
        end
        bus.col_valid = 1'b0;
        enable = 1'b1;
        wait_fv("flush");
        chk("flush_pre_count", fifo_count, 5);
        enable = 1'b0; flush = 1'b1;
        bus.col_valid = 1'b1; bus.col_data = 7'h55;
        cycle();
        flush = 1'b0; bus.col_valid = 1'b0;
        chk("flush_frame", bus.frame, 0);
        chk("flush_count", fifo_count, 0);
        chk("flush_fv", bus.frame_valid, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 399) == 0);
            flush         = ($urandom_range(0, 149) == 0);
            enable        = ($urandom_range(0, 7) != 0);
            bus.col_valid = ($urandom_range(0, 1) == 1);
            bus.col_data  = 7'($urandom);
            bus.frame_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shm_column_scroller.md
Name: shm_column_scroller

Overview:
Upstream frame source for the Scroll Hat Mini display driver. It accepts 7-bit LED columns through a valid/ready stream into a column FIFO. At a programmable scroll rate it shifts the 17x7 bitmap left by one column, feeding the new column in on the right. Each new bitmap is offered downstream on a frame valid/ready handshake, in the physical_leds layout the display updater consumes.

Parameters:
NUM_COLS, 17, display columns
NUM_ROWS, 7, display rows (column word width)
FIFO_DEPTH, 32, column FIFO entries (power of two)
TICK_DIV, 5_000_000, clk cycles per scroll step (100 ms at 50 MHz); minimum 2
PAD_BLANK, 1, 1: shift in an all-off column when the FIFO is empty at a step; 0: hold the frame

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
reset  in  1  synchronous, active-high reset
enable  in  1  scroll counter runs while high
flush  in  1  one-cycle pulse: clear FIFO and blank the display
col_valid  in  1  column word offered
col_data  in  NUM_ROWS  bit r = row r (row 0 = top), 1 = lit
col_ready  out  1  FIFO can accept; equals !full
frame  out  NUM_COLS*NUM_ROWS  bit (c + NUM_COLS*r) = column c (0 = left), row r
frame_valid  out  1  frame holds an unconsumed update
frame_ready  in  1  downstream consumed frame (transfer = valid & ready)
fifo_count  out  $clog2(FIFO_DEPTH+1)  columns queued
idle  out  1  FIFO empty and frame_valid low

Behaviour:
- One clock. Synchronous active-high reset. All state is registered.
- Reset values: frame=0, frame_valid=0, fifo empty (fifo_count=0, col_ready=1), tick counter=TICK_DIV-1, tick_due=0, idle=1.
- Push: accepted when col_valid & col_ready. col_ready depends only on full; there is no same-cycle pass-through when full.
- Tick counter: while enable=1, it decrements each cycle. At 0 it sets tick_due and reloads TICK_DIV-1. While enable=0 the counter holds and tick_due is retained. Ticks arriving while tick_due is already set merge into one.
- Shift is allowed when tick_due & (!frame_valid | frame_ready).
- Shift with FIFO non-empty:
  - New column c = old column c+1 for c = 0..NUM_COLS-2.
  - Column NUM_COLS-1 = FIFO head, popped in the same cycle.
  - frame_valid<=1, tick_due<=0.
- Shift with FIFO empty:
  - PAD_BLANK=1: shift in 0s; frame_valid<=1; tick_due<=0.
  - PAD_BLANK=0: frame unchanged; tick_due<=0; frame_valid unaffected.
- Handshake:
  - frame is stable while frame_valid & !frame_ready.
  - A transfer without a same-cycle shift clears frame_valid.
  - A transfer with a same-cycle shift leaves frame_valid=1, presenting the new frame next cycle.
- Latency: a column pushed into an empty FIFO appears at column NUM_COLS-1 on the next shift, visible the cycle after that shift.
- Simultaneous push and pop: both happen; fifo_count is unchanged.
- Flush (priority over shift, push and pop):
  - FIFO emptied, incoming push dropped, frame=0, frame_valid=1.
  - Counter reloads; tick_due=0.
- Reset mid-scroll: everything returns to reset values next cycle; an in-flight frame is discarded without a handshake.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count saturates at neither end: push when full and pop when empty are both impossible by construction.

Decomposition:
- Package shm_pkg: SHM_NUM_COLS=17, SHM_NUM_ROWS=7, SHM_NUM_LEDS=119, function shm_led_index(col,row)=col+17*row. The display updater uses the same package.
- Sub-module shm_col_fifo: synchronous FIFO with parameters WIDTH and DEPTH. Ports: push, pop, clear, din, dout (head, first-word-fall-through), full, empty, count.
- Tick counter and shift/handshake logic stay in shm_column_scroller.

Test Plan:
- Reset held for 3 cycles -> frame=0, frame_valid=0, col_ready=1, fifo_count=0, idle=1.
- TICK_DIV=4, enable=1, frame_ready=1; push col 7'h7F -> 4 cycles later frame[16+17*r]=1 for r=0..6, all other bits 0; frame_valid high for 1 cycle; fifo_count back to 0.
- TICK_DIV=4; push 17 columns k = 7'(k+1) for k=0..16, frame_ready=1 -> after the 17th shift, column c of frame = c+1; PAD_BLANK=1 18th shift gives column 16 = 0 and column 15 = 17.
- Backpressure: frame_valid=1 with frame_ready=0 for 40 cycles (TICK_DIV=4) and 3 columns queued -> frame stable, fifo_count stays 3. Raise frame_ready for one cycle -> exactly one shift, fifo_count=2.
- enable=0; push 33 columns back-to-back -> col_ready falls when fifo_count=32; 33rd not accepted; fifo_count=32.
- Mid-scroll flush with fifo_count=5 and frame non-zero -> next cycle frame=0, fifo_count=0, frame_valid=1. A simultaneous col_valid in the flush cycle is dropped.
